// File: rtl/gate_bist.sv
// Exhaustive self-checking sweep of a Not/Nand/And/Or/Xor gate bank.
// Optional GATE_BIST_STOP_ON_FAIL_EN ends the sweep on the first failing vector.
module gate_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] not_in,
  input  logic [WIDTH-1:0] nand_in,
  input  logic [WIDTH-1:0] and_in,
  input  logic [WIDTH-1:0] or_in,
  input  logic [WIDTH-1:0] xor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [4:0]       fail_mask,
  output logic [2:0]       dbgState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } stateT;

  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  stateT              state;
  logic [2*WIDTH-1:0] idx;
  logic [3:0]         settleCnt;
  logic [4:0]         mismatch;
  logic               anyMismatch;
  logic               lastVec;

  assign a_out    = idx[WIDTH-1:0];
  assign b_out    = idx[2*WIDTH-1:WIDTH];
  assign dbgState = state;

  // Golden values come from the registered operands, never from the returned results.
  assign mismatch = {xor_in  != (a_out ^ b_out),
                     or_in   != (a_out | b_out),
                     and_in  != (a_out & b_out),
                     nand_in != ~(a_out & b_out),
                     not_in  != ~a_out};
  assign anyMismatch = |mismatch;
  assign lastVec     = &idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      settleCnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_mask <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          settleCnt <= '0;
          state     <= (SETTLE == 0) ? CHECK : WAIT;
        end
        WAIT: begin
          if (settleCnt == SETTLE_LAST) state <= CHECK;
          else settleCnt <= settleCnt + 4'd1;
        end
        CHECK: begin
          if (anyMismatch) begin
            if (err_count == '0) begin
              fail_a    <= a_out;
              fail_b    <= b_out;
              fail_mask <= mismatch;
            end
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
          if (anyMismatch || lastVec) begin
`else
          if (lastVec) begin
`endif
            // A nonzero count can never return to zero, so this is the final tally.
            pass  <= (err_count == '0) && !anyMismatch;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: two instances (CNT_W=16 and CNT_W=4) with a behavioural gate bank.
module tb_gate_bist;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start2;
  logic       andStuck, xorInvert;

  logic [3:0]  a1, b1, notIn1, nandIn1, andIn1, orIn1, xorIn1, failA1, failB1;
  logic        busy1, done1, pass1;
  logic [15:0] err1;
  logic [4:0]  mask1;
  logic [2:0]  dbgState1;

  logic [3:0]  a2, b2, notIn2, nandIn2, andIn2, orIn2, xorIn2, failA2, failB2;
  logic        busy2, done2, pass2;
  logic [3:0]  err2;
  logic [4:0]  mask2;
  logic [2:0]  dbgState2;

  int evaluated = 0;
  int failures  = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  // behavioural gate bank, with fault controls
  assign notIn1  = ~a1;
  assign nandIn1 = ~(a1 & b1);
  assign andIn1  = (a1 & b1) & (andStuck ? 4'b1110 : 4'b1111);
  assign orIn1   = a1 | b1;
  assign xorIn1  = a1 ^ b1;

  assign notIn2  = ~a2;
  assign nandIn2 = ~(a2 & b2);
  assign andIn2  = a2 & b2;
  assign orIn2   = a2 | b2;
  assign xorIn2  = xorInvert ? ~(a2 ^ b2) : (a2 ^ b2);

  gate_bist #(.WIDTH(4), .SETTLE(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a_out(a1), .b_out(b1),
    .not_in(notIn1), .nand_in(nandIn1), .and_in(andIn1), .or_in(orIn1), .xor_in(xorIn1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(failA1), .fail_b(failB1), .fail_mask(mask1), .dbgState(dbgState1)
  );

  gate_bist #(.WIDTH(4), .SETTLE(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a_out(a2), .b_out(b2),
    .not_in(notIn2), .nand_in(nandIn2), .and_in(andIn2), .or_in(orIn2), .xor_in(xorIn2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_a(failA2), .fail_b(failB2), .fail_mask(mask2), .dbgState(dbgState2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic pulseStart1();
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
  endtask

  task automatic pulseStart2();
    @(negedge clk) start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
  endtask

  // Counts busy cycles until done; optionally injects start at startAt, or returns early at stopAt.
  task automatic waitDone1(input int startAt, input int stopAt, output int cycles);
    cycles = 0;
    while (!done1 && cycles < 2000 && cycles != stopAt) begin
      cycles++;
      if (dbgState1 == 3'd1 && exp_q.size() > 0) check("operand_seq", {b1, a1}, exp_q.pop_front());
      if (cycles == startAt) start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
    end
  endtask

  task automatic waitDone2(output int cycles);
    cycles = 0;
    while (!done2 && cycles < 2000) begin
      cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic checkIdealDone(input string tag, input int cycles);
    check({tag, "_cycles"}, cycles, 768);
    check({tag, "_done"}, done1, 1'b1);
    check({tag, "_busy"}, busy1, 1'b0);
    check({tag, "_pass"}, pass1, 1'b1);
    check({tag, "_err"}, err1, 16'd0);
    check({tag, "_mask"}, mask1, 5'd0);
    check({tag, "_a_hold"}, a1, 4'hf);
    check({tag, "_b_hold"}, b1, 4'hf);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; andStuck = 1'b0; xorInvert = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_pass", pass1, 1'b0);
    check("rst_err", err1, 16'd0);
    check("rst_ab", {b1, a1}, 8'h00);
    check("rst_fail", {failB1, failA1, mask1}, 13'd0);
    check("rst_state", dbgState1, 3'd0);
    check("rst_err2", err2, 4'd0);
    @(negedge clk) reset = 1'b0;

    // ideal sweep with full operand-order scoreboard
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    pulseStart1();
    check("busy_after_start", busy1, 1'b1);
    waitDone1(-1, -1, cyc);
    checkIdealDone("ideal", cyc);
    check("operand_seq_drained", exp_q.size(), 0);

    // start while busy is ignored
    pulseStart1();
    waitDone1(100, -1, cyc);
    checkIdealDone("start_busy", cyc);

    // asynchronous reset mid-sweep, then a clean sweep
    pulseStart1();
    waitDone1(-1, 300, cyc);
    check("mid_busy", busy1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy1, 1'b0);
    check("arst_ab", {b1, a1}, 8'h00);
    check("arst_err", err1, 16'd0);
    check("arst_done_pass", {done1, pass1}, 2'b00);
    check("arst_state", dbgState1, 3'd0);
    @(negedge clk) reset = 1'b0;
    pulseStart1();
    waitDone1(-1, -1, cyc);
    checkIdealDone("after_rst", cyc);

    // and_in bit0 stuck at 0
    andStuck = 1'b1;
    pulseStart1();
    waitDone1(-1, -1, cyc);
    check("and_done", done1, 1'b1);
    check("and_pass", pass1, 1'b0);
    check("and_fail_a", failA1, 4'd1);
    check("and_fail_b", failB1, 4'd1);
    check("and_mask", mask1, 5'b00100);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    check("and_cycles", cyc, 54);
    check("and_err", err1, 16'd1);
    check("and_ab_hold", {b1, a1}, 8'h11);
`else
    check("and_cycles", cyc, 768);
    check("and_err", err1, 16'd64);
    check("and_ab_hold", {b1, a1}, 8'hff);
`endif

    // start while done clears results and reruns
    andStuck = 1'b0;
    pulseStart1();
    check("restart_err", err1, 16'd0);
    check("restart_flags", {done1, pass1, busy1}, 3'b001);
    check("restart_fail", {failB1, failA1, mask1}, 13'd0);
    waitDone1(-1, -1, cyc);
    checkIdealDone("restart", cyc);

    // CNT_W=4, xor inverted: every vector fails
    xorInvert = 1'b1;
    pulseStart2();
    waitDone2(cyc);
    check("sat_done", done2, 1'b1);
    check("sat_pass", pass2, 1'b0);
    check("sat_fail_ab", {failB2, failA2}, 8'h00);
    check("sat_mask", mask2, 5'b10000);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    check("sat_cycles", cyc, 3);
    check("sat_err", err2, 4'd1);
`else
    check("sat_cycles", cyc, 768);
    check("sat_err", err2, 4'd15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
# gate_bist

Self-checking, parametrised exerciser for the Nand2Tetris primitive gate bank (Not, Nand, And, Or, Xor). It sweeps every combination of two WIDTH-bit operands, drives them to an external bit-parallel gate bank, and waits a programmable settle time. It then compares the five returned results against internal golden values and reports pass/fail, a mismatch count and the first failing vector. It sits beside the gate library as hardware replacement for hand-inspected `$monitor` sweeps.

## Interface
- WIDTH, 4, operand width in bits; legal 1..8.
- SETTLE, 1, wait cycles between driving operands and sampling results; legal 0..15.
- CNT_W, 16, width of the mismatch counter.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a sweep; sampled in IDLE or DONE only.
- a_out  out  WIDTH  operand A to the gate bank.
- b_out  out  WIDTH  operand B to the gate bank.
- not_in, nand_in, and_in, or_in, xor_in  in  WIDTH each  gate bank results; Not applies to A only.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until next start or reset.
- pass  out  1  done with zero mismatches.
- err_count  out  CNT_W  number of failing vectors, saturating.
- fail_a, fail_b  out  WIDTH  operands of first failing vector.
- fail_mask  out  5  ops failing on first failing vector: [0] not, [1] nand, [2] and, [3] or, [4] xor.

## Operation
- Vector index idx is 2*WIDTH bits. a_out = idx[WIDTH-1:0] and b_out = idx[2*WIDTH-1:WIDTH], so A toggles fastest.
- States:
  - IDLE: wait for start.
  - DRIVE: operands updated on entry.
  - WAIT: SETTLE cycles; skipped if SETTLE=0.
  - CHECK: compare and update.
  - DONE.
- start in IDLE/DONE:
  - Clear idx, err_count, fail_a, fail_b, fail_mask, pass and done.
  - Load operands for idx=0.
  - Go to DRIVE.
- start in DRIVE/WAIT/CHECK is ignored.
- Golden values: ~a, ~(a&b), a&b, a|b, a^b, all bitwise on the registered a_out/b_out.
- CHECK, per op: mismatch bit = (input != golden).
  - If any bit is set and err_count==0: capture fail_a, fail_b, fail_mask.
  - If any bit is set: err_count += 1, saturating at 2^CNT_W-1. One count per vector, regardless of how many ops fail.
- CHECK exit:
  - If idx is all-ones: go to DONE, done=1, pass=(final err_count==0).
  - Otherwise: idx+1 and operands load, then DRIVE.
- In DONE, a_out/b_out hold the last vector.

## Timing
- Reset values:
  - a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_a=0, fail_b=0, fail_mask=0.
  - state=IDLE, idx=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- busy rises the cycle after start is sampled and falls in the same cycle done rises.
- Per vector: 2+SETTLE cycles (DRIVE 1, WAIT SETTLE, CHECK 1). Results are sampled SETTLE+1 cycles after operands change.
- Full sweep: 4^WIDTH × (2+SETTLE) cycles from the first busy cycle to done.
- Reset asserted mid-sweep forces reset values immediately, regardless of clk. No partial result is retained.
- start and reset together: reset wins.
- Saturated err_count stays at maximum; fail_* are never overwritten after the first capture.

## Configuration
- GATE_BIST_STOP_ON_FAIL_EN defined:
  - CHECK with any mismatch goes directly to DONE after capturing.
  - err_count=1, pass=0, and a_out/b_out hold the failing vector.
- Undefined: the full sweep always completes, as described above.

## Test plan
- Ideal behavioural gate bank, WIDTH=4, SETTLE=1, pulse start -> busy high 768 cycles, then done=1, pass=1, err_count=0, fail_mask=0.
- and_in bit0 stuck at 0, same parameters -> done after 768 cycles, err_count=64, fail_a=1, fail_b=1, fail_mask=5'b00100, pass=0.
- Same fault with GATE_BIST_STOP_ON_FAIL_EN -> done after 54 cycles (vector 17), err_count=1, a_out=1, b_out=1.
- Reset pulsed at cycle 300 of an ideal sweep -> all outputs return to reset values asynchronously. A following start yields a full 768-cycle pass.
- start pulsed at cycle 100 while busy -> ignored, completion at cycle 768 unchanged. start while done -> counters cleared and sweep restarts.
- CNT_W=4 with xor_in inverted -> all 256 vectors fail, err_count saturates at 15, fail_a=0, fail_b=0, fail_mask=5'b10000.
